// File: rtl/sr_cmd_driver.sv
// rtl/sr_cmd_driver.sv - request-to-pulse command driver for a clocked SR flop
//
// Purpose: takes target-level requests over a valid/ready handshake and turns
// them into timed, never-overlapping s/r pulses. It keeps a mirror of the
// flop's q, skips requests that would not change q (unless forced), and flags
// any disagreement between the flop's q feedback and the mirror.
//
// Ports:
//   clk        in   1  clock, all logic on posedge
//   rst_n      in   1  asynchronous active-low reset
//   req_valid  in   1  request present
//   req_ready  out  1  driver can accept (IDLE and out of reset)
//   req_level  in   1  desired flop q (1 -> {s,r}=01, 0 -> {s,r}=10)
//   req_force  in   1  pulse even when req_level already equals q_mirror
//   fb_q       in   1  q fed back from the driven flop
//   s, r       out  1  registered flop controls
//   q_mirror   out  1  expected flop q
//   busy       out  1  a pulse or gap is in progress
//   cmd_count  out  8  issued (non-skipped) commands, wraps
//   mismatch   out  1  sticky fb_q != q_mirror seen while IDLE
module sr_cmd_driver #(
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 1,
  parameter bit INIT_Q    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_level,
  input  logic       req_force,
  input  logic       fb_q,
  output logic       s,
  output logic       r,
  output logic       q_mirror,
  output logic       busy,
  output logic [7:0] cmd_count,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // The down-counter is loaded with length-1 so that reaching zero marks the
  // last cycle of the phase.
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LAST   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       q_mirror_q, q_mirror_d;
  logic [7:0] cmd_count_q, cmd_count_d;
  logic       mismatch_q, mismatch_d;

  assign req_ready = (state_q == ST_IDLE) && rst_n;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    r_d         = r_q;
    q_mirror_d  = q_mirror_q;
    cmd_count_d = cmd_count_q;
    mismatch_d  = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        // Feedback is only trusted while no pulse is in flight.
        if (fb_q != q_mirror_q) begin
          mismatch_d = 1'b1;
        end
        if (req_valid && req_ready && (req_force || (req_level != q_mirror_q))) begin
          state_d     = ST_PULSE;
          cnt_d       = PULSE_LAST;
          s_d         = ~req_level;
          r_d         = req_level;
          q_mirror_d  = req_level;
          cmd_count_d = cmd_count_q + 8'd1;
        end
      end

      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          s_d = 1'b0;
          r_d = 1'b0;
          if (GAP_LEN == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      q_mirror_q  <= INIT_Q;
      cmd_count_q <= 8'd0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      q_mirror_q  <= q_mirror_d;
      cmd_count_q <= cmd_count_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign q_mirror  = q_mirror_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_count = cmd_count_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// tb/tb_sr_cmd_driver.sv - directed self-checking bench for sr_cmd_driver
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n;

  // Instance with PULSE_LEN=1, GAP_LEN=1
  logic       req_valid, req_ready, req_level, req_force, fb_q;
  logic       s, r, q_mirror, busy, mismatch;
  logic [7:0] cmd_count;

  // Instance with PULSE_LEN=3, GAP_LEN=0
  logic       v3, ready3, l3, f3, fb3;
  logic       s3, r3, mirror3, busy3, mismatch3;
  logic [7:0] count3;

  logic       flop_q  = 1'b1;
  logic       flop3_q = 1'b1;
  logic       stuck;

  int         checks = 0;
  int         errors = 0;
  int         sr_bad = 0;

  always #5 clk = ~clk;

  sr_cmd_driver #(.PULSE_LEN(1), .GAP_LEN(1), .INIT_Q(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_level(req_level), .req_force(req_force),
    .fb_q(fb_q), .s(s), .r(r), .q_mirror(q_mirror), .busy(busy),
    .cmd_count(cmd_count), .mismatch(mismatch)
  );

  sr_cmd_driver #(.PULSE_LEN(3), .GAP_LEN(0), .INIT_Q(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(ready3),
    .req_level(l3), .req_force(f3),
    .fb_q(fb3), .s(s3), .r(r3), .q_mirror(mirror3), .busy(busy3),
    .cmd_count(count3), .mismatch(mismatch3)
  );

  // Behavioural SR flops driven by each instance.
  always @(posedge clk) begin
    if ({s, r} == 2'b01) flop_q <= 1'b1;
    else if ({s, r} == 2'b10) flop_q <= 1'b0;
    if ({s3, r3} == 2'b01) flop3_q <= 1'b1;
    else if ({s3, r3} == 2'b10) flop3_q <= 1'b0;
  end
  assign fb_q = stuck ? 1'b1 : flop_q;
  assign fb3  = flop3_q;

  always @(negedge clk) begin
    if (rst_n) begin
      if (s & r) sr_bad++;
      if ((s | r) && !busy) sr_bad++;
      if (s3 & r3) sr_bad++;
      if ((s3 | r3) && !busy3) sr_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mc;
    logic       mm;
    logic       lv;
    logic       fv;
    int         guard;
    int         n;
    int         hi;
    logic [7:0] c0;

    rst_n = 1'b0;
    req_valid = 1'b0; req_level = 1'b0; req_force = 1'b0;
    v3 = 1'b0; l3 = 1'b0; f3 = 1'b0;
    stuck = 1'b0;
    tick; tick;

    // Reset state
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_mirror", q_mirror, 1);
    check("rst_count", cmd_count, 0);
    check("rst_busy", busy, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_ready_low", req_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", req_ready, 1);

    // T1: async reset mid-pulse
    req_valid = 1'b1; req_level = 1'b0;
    tick;
    req_valid = 1'b0;
    check("t1_s_pulse", s, 1);
    check("t1_count1", cmd_count, 1);
    check("t1_mirror0", q_mirror, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_s_dropped", {s, r}, 2'b00);
    check("t1_mirror", q_mirror, 1);
    check("t1_count0", cmd_count, 0);
    tick;
    rst_n = 1'b1;
    #1;
    check("t1_ready", req_ready, 1);

    // T2: clear then set, P=1 G=1
    req_valid = 1'b1; req_level = 1'b0;
    tick;                                   // edge N
    req_valid = 1'b0;
    check("t2_clr_sr", {s, r}, 2'b10);
    check("t2_clr_ready", req_ready, 0);
    check("t2_clr_count", cmd_count, 1);
    tick;                                   // N+1
    check("t2_clr_off", {s, r}, 2'b00);
    check("t2_gap_busy", busy, 1);
    check("t2_gap_ready", req_ready, 0);
    tick;                                   // N+2
    check("t2_idle_ready", req_ready, 1);
    check("t2_idle_busy", busy, 0);
    req_valid = 1'b1; req_level = 1'b1;
    tick;                                   // N+3 accept
    check("t2_set_sr", {s, r}, 2'b01);
    check("t2_set_count", cmd_count, 2);
    check("t2_set_mirror", q_mirror, 1);
    req_level = 1'b0;                       // ignored while busy
    tick;
    req_valid = 1'b0;
    check("t2_ignored_count", cmd_count, 2);
    check("t2_ignored_mirror", q_mirror, 1);
    tick;
    check("t2_mismatch", mismatch, 0);

    // T3: skip, then forced pulse
    req_valid = 1'b1; req_level = 1'b1; req_force = 1'b0;
    tick;
    check("t3_skip_ready", req_ready, 1);
    check("t3_skip_sr", {s, r}, 2'b00);
    check("t3_skip_count", cmd_count, 2);
    req_force = 1'b1;
    tick;
    req_valid = 1'b0; req_force = 1'b0;
    check("t3_force_sr", {s, r}, 2'b01);
    check("t3_force_count", cmd_count, 3);
    tick; tick;

    // T4: P=3 G=0 widths and spacing
    v3 = 1'b1; l3 = 1'b0;
    tick;
    v3 = 1'b0;
    check("t4_s_c0", s3, 1);
    tick;
    check("t4_s_c1", s3, 1);
    tick;
    check("t4_s_c2", s3, 1);
    tick;
    check("t4_s_off", s3, 0);
    check("t4_ready", ready3, 1);
    check("t4_count1", count3, 1);
    v3 = 1'b1; l3 = 1'b1;
    tick;                                   // edge M
    check("t4_r_on", r3, 1);
    check("t4_count2", count3, 2);
    l3 = 1'b0;
    c0 = count3; n = 0; hi = 1;
    while (n < 20) begin
      tick;
      n++;
      if (count3 != c0) break;
      if (s3 | r3) hi++;
    end
    v3 = 1'b0;
    check("t4_spacing", n, 4);
    check("t4_pulse_width", hi, 3);
    check("t4_count3", count3, 3);

    // T5: 300 accepts with valid held high
    mc = 8'd3; mm = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      fv = ($urandom_range(0, 3) == 0);
      lv = ($urandom_range(0, 9) == 0) ? mm : ~mm;
      req_level = lv; req_force = fv;
      guard = 0;
      while (!req_ready && guard < 20) begin
        tick;
        guard++;
      end
      if (guard >= 20) begin
        check("t5_ready_timeout", guard, 0);
        break;
      end
      tick;                                 // accept edge
      if (fv || (lv != mm)) begin
        mc = mc + 8'd1;
        mm = lv;
      end
    end
    req_valid = 1'b0; req_force = 1'b0;
    tick; tick; tick;
    check("t5_count", cmd_count, mc);
    check("t5_mirror", q_mirror, mm);
    check("t5_mismatch", mismatch, 0);
    check("t5_sr_invariant", sr_bad, 0);

    // T6: stuck feedback after a clear
    req_valid = 1'b1; req_level = 1'b1; req_force = 1'b1;
    tick;
    req_valid = 1'b0; req_force = 1'b0;
    tick; tick;
    stuck = 1'b1;
    req_valid = 1'b1; req_level = 1'b0;
    tick;                                   // N
    req_valid = 1'b0;
    tick;                                   // N+1
    tick;                                   // N+2, first IDLE cycle
    check("t6_before", mismatch, 0);
    check("t6_mirror", q_mirror, 0);
    tick;                                   // N+3
    check("t6_set", mismatch, 1);
    tick; tick; tick;
    check("t6_held", mismatch, 1);
    check("t6_count", cmd_count, mc + 8'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_clear", mismatch, 0);
    stuck = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
